// File: rtl/modmul_operand_mult.sv
// ============================================================================
// Module : modmul_operand_mult
// Brief  : Sequential shift-and-add WIDTH x WIDTH multiplier whose 2*WIDTH-bit
//          product is split into P_hi/P_lo for the downstream divider.
//          Optional macro MODMUL_EARLY_TERM_EN ends the run once the multiplier
//          has no set bits left.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module modmul_operand_mult #(
  parameter int WIDTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] P_hi,
  output logic [WIDTH-1:0] P_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic               done_q,   done_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MODMUL_EARLY_TERM_EN
    // Remaining multiplier bits all zero: further iterations cannot change acc.
    last_iter = (count_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    last_iter = (count_q == CW'(1));
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    prod_d   = prod_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = CW'(WIDTH);
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          prod_d  = acc_sum;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = done_q;
    P_hi = prod_q[2*WIDTH-1:WIDTH];
    P_lo = prod_q[WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_modmul_operand_mult.sv
// ============================================================================
// Module : tb_modmul_operand_mult
// Brief  : Scoreboard bench for modmul_operand_mult at WIDTH=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_modmul_operand_mult;

  localparam int WIDTH = 8;

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] P_hi;
  logic [WIDTH-1:0] P_lo;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  modmul_operand_mult #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P_hi  (P_hi),
    .P_lo  (P_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [WIDTH-1:0] b);
`ifdef MODMUL_EARLY_TERM_EN
    int m = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) m = i + 1;
    return (m < 1) ? 1 : m;
`else
    return WIDTH;
`endif
  endfunction

  // Done-side scoreboard: every done pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse_width", {63'd0, prev_done}, 64'd0);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product", {48'd0, P_hi, P_lo}, e.p);
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_done = done;
  end

  // Called at a negedge; the following posedge accepts the request.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    A = a;
    B = b;
    start = 1'b1;
    e.p   = 64'(a) * 64'(b);
    e.cyc = cyc + 1 + lat(b);
    sb.push_back(e);
  endtask

  task automatic wait_done(input logic hold, output int nbusy);
    logic got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 4 * WIDTH + 8 && !got; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) nbusy++;
      if (done) got = 1'b1;
    end
    check("done_timeout", {63'd0, got}, 64'd1);
  endtask

  initial begin
    int          nb;
    logic [7:0]  ra, rb, rm;
    logic [15:0] prod;

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_p", {48'd0, P_hi, P_lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic all-ones
    launch(8'hFF, 8'hFF);
    wait_done(1'b0, nb);
    check("basic_busy_cycles", 64'(nb), 64'(lat(8'hFF)));
    check("basic_phi", {56'd0, P_hi}, 64'hFE);
    check("basic_plo", {56'd0, P_lo}, 64'h01);

    // Reset mid-run aborts without a done pulse
    @(negedge clk);
    launch(8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_p", {48'd0, P_hi, P_lo}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(8'h03, 8'h05);
    wait_done(1'b0, nb);
    check("post_rst_p", {48'd0, P_hi, P_lo}, 64'h000F);

    // Back-to-back: start held through done, second op taken on done cycle
    @(negedge clk);
    launch(8'h12, 8'h34);
    wait_done(1'b1, nb);
    launch(8'h80, 8'h02);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", {63'd0, busy}, 64'd1);
    check("b2b_hold_p", {48'd0, P_hi, P_lo}, 64'h03A8);
    wait_done(1'b0, nb);
    check("b2b_second_p", {48'd0, P_hi, P_lo}, 64'h0100);

    // Start while busy is ignored
    @(negedge clk);
    launch(8'h10, 8'h10);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'h01;
    B = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, nb);
    check("ignored_p", {48'd0, P_hi, P_lo}, 64'h0100);
    repeat (12) @(negedge clk);

    // Early-termination patterns (fixed latency when the macro is off)
    launch(8'h07, 8'h05);
    wait_done(1'b0, nb);
    check("b05_busy_cycles", 64'(nb), 64'(lat(8'h05)));
    @(negedge clk);
    launch(8'h5A, 8'h00);
    wait_done(1'b0, nb);
    check("b00_p", {48'd0, P_hi, P_lo}, 64'h0000);
    @(negedge clk);
    launch(8'h00, 8'hC3);
    wait_done(1'b0, nb);

    // Random operands, also reduced by a random modulus as the divider would
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 8'($urandom_range(1, 127));
      launch(ra, rb);
      wait_done(1'b0, nb);
      prod = {P_hi, P_lo};
      check("rand_mod", 64'(prod % 16'(rm)), 64'((16'(ra) * 16'(rb)) % 16'(rm)));
    end

    repeat (4) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
